// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if: key/tick inputs, counter carries and counter strobes of the set controller.
interface clock_set_controller_if;
  logic       i_tick;
  logic       i_mode;
  logic       i_inc;
  logic       i_dec;
  logic       i_sec_carry;
  logic       i_min_carry;
  logic       o_sec_up;
  logic       o_sec_down;
  logic       o_min_up;
  logic       o_min_down;
  logic       o_hour_up;
  logic       o_hour_down;
  logic [1:0] o_state;
  logic       o_blank;
  modport master (
    output i_tick, i_mode, i_inc, i_dec, i_sec_carry, i_min_carry,
    input  o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down, o_state, o_blank
  );
  modport slave (
    input  i_tick, i_mode, i_inc, i_dec, i_sec_carry, i_min_carry,
    output o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down, o_state, o_blank
  );
endinterface

// File: rtl/clock_set_controller.sv
// clock_set_controller: RUN/set-mode sequencer driving the sec/min/hour counter chain.
// Define AUTO_REPEAT_EN to build held-key auto-repeat in the set modes.
module clock_set_controller #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  parameter int BLINK_HALF = 25_000_000
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  clock_set_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_e;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  if (REPEAT_DLY < 1 || REPEAT_PER < 1 || BLINK_HALF < 1) begin : g_bad_cfg
    $error("clock_set_controller: REPEAT_DLY, REPEAT_PER and BLINK_HALF must be >= 1");
  end
  state_e          state_q, state_d;
  logic            mode_q, inc_q, dec_q;
  logic            sec_up_q, sec_up_d, sec_dn_q, sec_dn_d;
  logic            min_up_q, min_up_d, min_dn_q, min_dn_d;
  logic            hour_up_q, hour_up_d, hour_dn_q, hour_dn_d;
  logic            prop_q, prop_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic            mode_ev, inc_ev, dec_ev, set_mode;
  logic            rpt_fire, step_up, step_dn, edit;
  assign mode_ev  = bus.i_mode & ~mode_q;
  assign inc_ev   = bus.i_inc & ~inc_q;
  assign dec_ev   = bus.i_dec & ~dec_q;
  assign set_mode = state_q != RUN;
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          solo;
  // Down-counter to the next step; reloaded whenever the single-key hold is broken or restarted
  assign solo     = set_mode & (bus.i_inc ^ bus.i_dec);
  assign rpt_fire = solo & ~inc_ev & ~dec_ev & (rpt_q == '0);
  always_comb begin
    rpt_d = (!solo || inc_ev || dec_ev || state_d != state_q) ? RW'(REPEAT_DLY - 1) :
            rpt_fire ? RW'(REPEAT_PER - 1) : rpt_q - RW'(1);
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rpt_q <= '0;
    else rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif
  assign step_up = set_mode & (inc_ev | (rpt_fire & bus.i_inc));
  assign step_dn = set_mode & (dec_ev | (rpt_fire & bus.i_dec));
  assign edit    = step_up | step_dn;
  always_comb begin
    state_d   = mode_ev ? state_e'(state_q + 2'd1) : state_q;
    prop_d    = (state_q == RUN) & bus.i_tick;
    sec_up_d  = ((state_q == RUN) & bus.i_tick) | ((state_q == SET_SEC) & step_up);
    sec_dn_d  = (state_q == SET_SEC) & step_dn;
    min_up_d  = (state_q == SET_MIN) & step_up;
    min_dn_d  = (state_q == SET_MIN) & step_dn;
    hour_up_d = (state_q == SET_HOUR) & step_up;
    hour_dn_d = (state_q == SET_HOUR) & step_dn;
    blink_d   = '0;
    phase_d   = 1'b0;
    if (set_mode && !edit && state_d == state_q) begin
      blink_d = (blink_q == BW'(BLINK_HALF - 1)) ? '0 : blink_q + BW'(1);
      phase_d = (blink_q == BW'(BLINK_HALF - 1)) ? ~phase_q : phase_q;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= RUN;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      sec_up_q  <= 1'b0;
      sec_dn_q  <= 1'b0;
      min_up_q  <= 1'b0;
      min_dn_q  <= 1'b0;
      hour_up_q <= 1'b0;
      hour_dn_q <= 1'b0;
      prop_q    <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= bus.i_mode;
      inc_q     <= bus.i_inc;
      dec_q     <= bus.i_dec;
      sec_up_q  <= sec_up_d;
      sec_dn_q  <= sec_dn_d;
      min_up_q  <= min_up_d;
      min_dn_q  <= min_dn_d;
      hour_up_q <= hour_up_d;
      hour_dn_q <= hour_dn_d;
      prop_q    <= prop_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
    end
  end
  // Carries ripple combinationally so all three fields step on the same edge
  assign bus.o_sec_up    = sec_up_q;
  assign bus.o_sec_down  = sec_dn_q;
  assign bus.o_min_up    = min_up_q | (prop_q & bus.i_sec_carry);
  assign bus.o_min_down  = min_dn_q;
  assign bus.o_hour_up   = hour_up_q | (prop_q & bus.i_min_carry);
  assign bus.o_hour_down = hour_dn_q;
  assign bus.o_state     = state_q;
  assign bus.o_blank     = phase_q & set_mode;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: table vectors, corner sequences and random stimulus against a reference model.
module tb_clock_set_controller;
  localparam int DLY = 8, PER = 4, HALF = 6;
`ifdef AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  clock_set_controller_if bus();
  clock_set_controller #(.REPEAT_DLY(DLY), .REPEAT_PER(PER), .BLINK_HALF(HALF)) dut (
    .i_clk(clk), .i_rstn(rstn), .bus(bus.slave)
  );
  int sec_c, min_c, hr_c;
  assign bus.i_sec_carry = bus.o_sec_up && sec_c == 59;
  assign bus.i_min_carry = bus.o_min_up && min_c == 59;
  int n_chk = 0, n_pass = 0;
  int mst, hold, bn;
  logic pmo, pin, pde;
  logic [1:0] e_st;
  logic e_bl, e_su, e_sd, e_mu, e_md, e_hu, e_hd, e_prop;
  typedef struct {logic t, mo, in, de; logic [8:0] ex;} vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
  endtask
  function automatic logic [8:0] obs();
    return {bus.o_state, bus.o_blank, bus.o_sec_up, bus.o_sec_down, bus.o_min_up,
            bus.o_min_down, bus.o_hour_up, bus.o_hour_down};
  endfunction
  function automatic logic [8:0] mk(input int st, bl, su, sd, mu, md, hu, hd);
    return {st[1:0], bl[0], su[0], sd[0], mu[0], md[0], hu[0], hd[0]};
  endfunction
  function automatic logic [8:0] expv();
    logic sc;
    sc = e_prop && sec_c == 59;
    return {e_st, e_bl, e_su, e_sd, e_mu | sc, e_md, e_hu | (sc && min_c == 59), e_hd};
  endfunction
  task automatic reset_model();
    mst = 0; hold = 0; bn = 0; pmo = 0; pin = 0; pde = 0;
    {e_st, e_bl, e_su, e_sd, e_mu, e_md, e_hu, e_hd, e_prop} = '0;
  endtask
  task automatic cnt_update();
    logic [8:0] o;
    o = obs();
    if (o[5] && o[4]) sec_c = 0; else if (o[5]) sec_c = (sec_c + 1) % 60; else if (o[4]) sec_c = (sec_c + 59) % 60;
    if (o[3] && o[2]) min_c = 0; else if (o[3]) min_c = (min_c + 1) % 60; else if (o[2]) min_c = (min_c + 59) % 60;
    if (o[1] && o[0]) hr_c = 0; else if (o[1]) hr_c = (hr_c + 1) % 24; else if (o[0]) hr_c = (hr_c + 23) % 24;
  endtask
  task automatic model(input logic t, mo, in, de);
    logic mev, iev, dev, rstep, up, dn, set;
    mev = mo && !pmo; iev = in && !pin; dev = de && !pde;
    pmo = mo; pin = in; pde = de;
    set = mst != 0;
    rstep = 1'b0;
    if (set && (in ^ de)) begin
      hold = (iev || dev) ? 0 : hold + 1;
      rstep = RPT && hold >= DLY && (hold - DLY) % PER == 0;
    end else hold = 0;
    up = set && (iev || (rstep && in));
    dn = set && (dev || (rstep && de));
    e_prop = mst == 0 && t;
    e_su = e_prop || (mst == 3 && up);
    e_sd = mst == 3 && dn;
    e_mu = mst == 2 && up;
    e_md = mst == 2 && dn;
    e_hu = mst == 1 && up;
    e_hd = mst == 1 && dn;
    if (mev) begin
      mst = (mst + 1) % 4;
      hold = 0;
    end
    bn = (mev || up || dn || mst == 0) ? 0 : bn + 1;
    e_st = 2'(mst);
    e_bl = mst != 0 && (bn / HALF) % 2 == 1;
  endtask
  task automatic cyc(input logic t, mo, in, de);
    cnt_update();
    bus.i_tick = t; bus.i_mode = mo; bus.i_inc = in; bus.i_dec = de;
    model(t, mo, in, de);
    @(posedge clk);
    @(negedge clk);
    chk("cycle_outputs", obs(), expv());
  endtask
  task automatic do_reset();
    bus.i_tick = 0; bus.i_mode = 0; bus.i_inc = 0; bus.i_dec = 0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", obs(), 0);
    reset_model();
    rstn = 1'b1;
  endtask
  initial begin
    longint mask, emask;
    int ones, keep_min;
    logic rm, ri, rd;
    do_reset();
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 1)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(2, 0, 0, 0, 1, 1, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3, 0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 0, 1, 0, 0, 0, 0)};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    sec_c = 0; min_c = 0; hr_c = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].t, tbl[i].mo, tbl[i].in, tbl[i].de);
      chk($sformatf("table_%0d", i), obs(), tbl[i].ex);
    end
    do_reset();
    sec_c = 0; min_c = 0; hr_c = 0;
    repeat (10) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("tick_sec_up", bus.o_sec_up, 1);
    chk("tick_state_blank", {bus.o_state, bus.o_blank}, 0);
    cyc(0, 0, 0, 0);
    chk("tick_one_cycle", bus.o_sec_up, 0);
    hr_c = 23; min_c = 59; sec_c = 59;
    cyc(1, 0, 0, 0);
    chk("rollover_strobes", {bus.o_sec_up, bus.o_min_up, bus.o_hour_up}, 3'b111);
    cyc(0, 0, 0, 0);
    chk("rollover_time", hr_c * 3600 + min_c * 60 + sec_c, 0);
    cyc(0, 1, 0, 0);
    chk("mode_to_set_hour", bus.o_state, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("set_hour_inc", {bus.o_hour_up, bus.o_min_up, bus.o_sec_up}, 3'b100);
    cyc(0, 0, 0, 0);
    chk("set_hour_inc_one_cycle", bus.o_hour_up, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("paused_tick", {bus.o_sec_up, bus.o_min_up, bus.o_hour_up}, 0);
    end
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("at_set_sec", bus.o_state, 3);
    sec_c = 59;
    keep_min = min_c;
    cyc(0, 0, 1, 1);
    chk("inc_dec_same_cycle", {bus.o_sec_up, bus.o_sec_down, bus.o_min_up}, 3'b110);
    cyc(0, 0, 0, 0);
    chk("sec_cleared", sec_c, 0);
    chk("no_min_carry_from_edit", min_c, keep_min);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("at_set_min", bus.o_state, 2);
    ones = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 0, 0);
      ones += int'(bus.o_blank);
    end
    chk("blink_duty", ones, 12);
    repeat (6) cyc(0, 0, 0, 0);
    chk("blank_on", bus.o_blank, 1);
    cyc(0, 0, 0, 1);
    chk("dec_clears_blank", {bus.o_blank, bus.o_min_down}, 2'b01);
    repeat (5) cyc(0, 0, 0, 0);
    chk("blank_restart_low", bus.o_blank, 0);
    cyc(0, 0, 0, 0);
    chk("blank_restart_high", bus.o_blank, 1);
    mask = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, k < 30, 0);
      if (bus.o_min_up) mask |= longint'(1) << (k + 1);
    end
    emask = longint'(1) << 1;
    if (RPT) for (int j = DLY; j < 30; j += PER) emask |= longint'(1) << (j + 1);
    chk("held_inc_pulses", mask, emask);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    sec_c = 10;
    cyc(1, 0, 0, 0);
    chk("pre_reset_strobe", bus.o_sec_up, 1);
    rstn = 1'b0;
    #1;
    chk("async_reset", obs(), 0);
    reset_model();
    @(negedge clk);
    rstn = 1'b1;
    rm = 0; ri = 0; rd = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(49) == 0) begin
        sec_c = $urandom_range(59, 54); min_c = $urandom_range(59, 57); hr_c = $urandom_range(23);
      end
      if ($urandom_range(9) == 0) rm = !rm;
      if ($urandom_range(9) == 0) ri = !ri;
      if ($urandom_range(9) == 0) rd = !rd;
      cyc($urandom_range(4) == 0, rm, ri, rd);
    end
    cyc(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
